// File: rtl/proc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// proc_ctrl_pkg : shared types and field positions for the proc control unit
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package proc_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ALU_R = 4'h1,
    OP_ALU_I = 4'h2,
    OP_BR    = 4'h8,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  // rb shares bits with the upper nibble of imm
  localparam int OP_HI  = 23;
  localparam int OP_LO  = 20;
  localparam int FN_HI  = 19;
  localparam int FN_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 8;
  localparam int RB_HI  = 7;
  localparam int RB_LO  = 4;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [1:0] SEL_REGS = 2'b00;
  localparam logic [1:0] SEL_CTE  = 2'b10;

  function automatic logic br_cond(input logic [2:0] sel, input logic [4:0] flags);
    logic r;
    case (sel)
      3'd0:    r = flags[0];
      3'd1:    r = flags[1];
      3'd2:    r = flags[2];
      3'd3:    r = flags[3];
      3'd4:    r = flags[4];
      3'd7:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/proc_ctrl_decoder.sv
// ----------------------------------------------------------------------------
// proc_ctrl_decoder : opcode -> instruction class flags (PROC_CTRL_BRANCH_EN)
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module proc_ctrl_decoder
  import proc_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output logic       we,
  output logic       use_imm,
  output logic       is_br,
  output logic       is_halt,
  output logic       illegal
);

  always_comb begin
    we      = 1'b0;
    use_imm = 1'b0;
    is_br   = 1'b0;
    is_halt = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_NOP:   ;
      OP_ALU_R: we = 1'b1;
      OP_ALU_I: begin
        we      = 1'b1;
        use_imm = 1'b1;
      end
`ifdef PROC_CTRL_BRANCH_EN
      OP_BR:    is_br = 1'b1;
`endif
      OP_HALT:  is_halt = 1'b1;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/proc_control_unit.sv
// ----------------------------------------------------------------------------
// proc_control_unit : multi-cycle fetch/decode/exec sequencer for the 8-bit
//                     datapath; branches enabled by PROC_CTRL_BRANCH_EN
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module proc_control_unit
  import proc_ctrl_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic [4:0]         cmp_flags,
  output logic [3:0]         SBA,
  output logic [3:0]         SBB,
  output logic [3:0]         SRD,
  output logic [3:0]         SULA,
  output logic [1:0]         selMuxCTE,
  output logic [7:0]         CTE,
  output logic               LE,
  output logic               busy,
  output logic               halted,
  output logic               illegal
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               illegal_q, illegal_d;

  logic dec_we, dec_use_imm, dec_is_br, dec_is_halt, dec_illegal;
  logic br_taken;

  proc_ctrl_decoder u_decoder (
    .op      (instr_q[OP_HI:OP_LO]),
    .we      (dec_we),
    .use_imm (dec_use_imm),
    .is_br   (dec_is_br),
    .is_halt (dec_is_halt),
    .illegal (dec_illegal)
  );

`ifdef PROC_CTRL_BRANCH_EN
  assign br_taken = dec_is_br & br_cond(instr_q[FN_LO+2:FN_LO], cmp_flags);
`else
  logic unused_br;
  assign unused_br = ^{cmp_flags, dec_is_br};
  assign br_taken  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = dec_is_halt ? ST_HALT : ST_FETCH;
        if (dec_illegal) illegal_d = 1'b1;
        // pc already advanced at fetch; a taken branch overrides it
        if (br_taken) pc_d = PC_W'(instr_q[IMM_HI:IMM_LO]);
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    SBA       = 4'h0;
    SBB       = 4'h0;
    SRD       = 4'h0;
    SULA      = 4'h0;
    selMuxCTE = SEL_REGS;
    CTE       = 8'h00;
    LE        = 1'b0;
    case (state_q)
      ST_FETCH: imem_req = 1'b1;
      ST_DECODE, ST_EXEC: begin
        SBA       = instr_q[RA_HI:RA_LO];
        SBB       = instr_q[RB_HI:RB_LO];
        SULA      = instr_q[FN_HI:FN_LO];
        selMuxCTE = dec_use_imm ? SEL_CTE : SEL_REGS;
        CTE       = instr_q[IMM_HI:IMM_LO];
        // DECODE is a settle cycle; the bank only writes on the EXEC edge
        if (state_q == ST_EXEC) begin
          SRD = instr_q[RD_HI:RD_LO];
          LE  = dec_we;
        end
      end
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted    = (state_q == ST_HALT);
  assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_proc_control_unit.sv
// ----------------------------------------------------------------------------
// tb_proc_control_unit : vector table + random instruction stream bench
// Revision             : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_proc_control_unit;

`ifdef PROC_CTRL_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [23:0] imem_data;
  logic [4:0]  cmp_flags;
  logic [3:0]  SBA, SBB, SRD, SULA;
  logic [1:0]  selMuxCTE;
  logic [7:0]  CTE;
  logic        LE, busy, halted, illegal;

  proc_control_unit #(.PC_W(8), .INSTR_W(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .cmp_flags (cmp_flags),
    .SBA       (SBA),
    .SBB       (SBB),
    .SRD       (SRD),
    .SULA      (SULA),
    .selMuxCTE (selMuxCTE),
    .CTE       (CTE),
    .LE        (LE),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {SBA, SBB, SRD, SULA, selMuxCTE, CTE, LE}
  logic [26:0] sel_bus;
  assign sel_bus = {SBA, SBB, SRD, SULA, selMuxCTE, CTE, LE};

  typedef struct {
    logic [26:0] ex;     // expected sel_bus during EXEC
    logic        taken;  // branch redirects pc to imm
    logic        ill;    // this instruction is undefined
    logic        halt;
  } exp_t;

  typedef struct {
    logic [23:0] ins;
    logic [4:0]  flags;
    int          waitc;
    exp_t        e;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] pc_m;
  logic       ill_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [23:0] ins, input logic [4:0] flags, input int waitc,
                              input logic [26:0] ex, input logic taken, input logic ill);
    vec_t v;
    v.ins     = ins;
    v.flags   = flags;
    v.waitc   = waitc;
    v.e.ex    = ex;
    v.e.taken = taken;
    v.e.ill   = ill;
    v.e.halt  = 1'b0;
    return v;
  endfunction

  // Reference: instruction semantics straight from the field layout
  function automatic exp_t model(input logic [23:0] ins, input logic [4:0] flags);
    exp_t e;
    int w, op, fn, rd, ra, rb, imm, c;
    bit alu, br, known;
    w   = int'(ins);
    op  = (w >> 20) & 15;
    fn  = (w >> 16) & 15;
    rd  = (w >> 12) & 15;
    ra  = (w >> 8) & 15;
    rb  = (w >> 4) & 15;
    imm = w & 255;
    alu   = (op == 1) || (op == 2);
    br    = (op == 8) && BR_EN;
    known = (op == 0) || alu || br || (op == 15);
    c     = fn % 8;
    e.taken = br && ((c <= 4 && flags[c] == 1'b1) || c == 7);
    e.ex    = {4'(ra), 4'(rb), 4'(rd), 4'(fn), (op == 2) ? 2'b10 : 2'b00, 8'(imm), alu};
    e.ill   = !known;
    e.halt  = (op == 15);
    return e;
  endfunction

  task automatic run_instr(input logic [23:0] ins, input logic [4:0] flags, input int waitc,
                           input exp_t e);
    int n;
    int req_seen;
    cmp_flags = flags;
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) begin
      chk("req_timeout", 64'(imem_req), 64'd1);
      return;
    end
    chk("fetch_addr", 64'(imem_addr), 64'(pc_m));
    req_seen = 1;
    for (int i = 0; i < waitc; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      if (imem_req === 1'b1) req_seen++;
    end
    imem_ack  = 1'b1;
    imem_data = ins;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 24'($urandom);
    chk("req_hold", 64'(req_seen), 64'(waitc + 1));
    chk("decode_bus", 64'(sel_bus), 64'({e.ex[26:19], 4'h0, e.ex[14:1], 1'b0}));
    chk("decode_state", 64'({imem_req, busy, halted}), 64'(3'b010));
    @(negedge clk);
    chk("exec_bus", 64'(sel_bus), 64'(e.ex));
    @(negedge clk);
    pc_m  = e.taken ? e.ex[8:1] : pc_m + 8'd1;
    ill_m = ill_m | e.ill;
    chk("illegal", 64'(illegal), 64'(ill_m));
    if (e.halt) begin
      chk("halt_state", 64'({imem_req, busy, halted}), 64'(3'b001));
    end else begin
      chk("next_fetch", 64'({imem_req, busy, halted}), 64'(3'b110));
      chk("next_pc", 64'(imem_addr), 64'(pc_m));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[9];
    logic [3:0] ops[10];
    logic [23:0] ins;
    logic [4:0]  flg;
    int          guard;

    tbl[0] = mk(24'h132100, 5'h00, 3, {4'h1, 4'h0, 4'h2, 4'h3, 2'b00, 8'h00, 1'b1}, 1'b0, 1'b0);
    tbl[1] = mk(24'h2546AB, 5'h00, 1, {4'h6, 4'hA, 4'h4, 4'h5, 2'b10, 8'hAB, 1'b1}, 1'b0, 1'b0);
    tbl[2] = mk(24'h0ABCDE, 5'h1F, 0, {4'hC, 4'hD, 4'hB, 4'hA, 2'b00, 8'hDE, 1'b0}, 1'b0, 1'b0);
    tbl[3] = mk(24'h820040, 5'b00100, 0, {4'h0, 4'h4, 4'h0, 4'h2, 2'b00, 8'h40, 1'b0}, BR_EN, !BR_EN);
    tbl[4] = mk(24'h820040, 5'b00011, 2, {4'h0, 4'h4, 4'h0, 4'h2, 2'b00, 8'h40, 1'b0}, 1'b0, !BR_EN);
    tbl[5] = mk(24'h870010, 5'h00, 0, {4'h0, 4'h1, 4'h0, 4'h7, 2'b00, 8'h10, 1'b0}, BR_EN, !BR_EN);
    tbl[6] = mk(24'h850020, 5'h1F, 1, {4'h0, 4'h2, 4'h0, 4'h5, 2'b00, 8'h20, 1'b0}, 1'b0, !BR_EN);
    tbl[7] = mk(24'h5F1234, 5'h00, 0, {4'h2, 4'h3, 4'h1, 4'hF, 2'b00, 8'h34, 1'b0}, 1'b0, 1'b1);
    tbl[8] = mk(24'h1E9870, 5'h00, 0, {4'h8, 4'h7, 4'h9, 4'hE, 2'b00, 8'h70, 1'b1}, 1'b0, 1'b0);
    ops = '{4'h0, 4'h1, 4'h2, 4'h8, 4'h3, 4'h5, 4'h9, 4'hC, 4'h1, 4'h2};

    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = 24'h0; cmp_flags = 5'h0;
    pc_m = 8'h00; ill_m = 1'b0;

    // Reset and idle: ack pulses must not wake the sequencer
    repeat (2) @(negedge clk);
    chk("reset_outs", {sel_bus, imem_req, imem_addr, busy, halted, illegal}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_ack  = ~imem_ack;
      imem_data = 24'($urandom);
      @(negedge clk);
      chk("idle_outs", {sel_bus, imem_req, imem_addr, busy, halted, illegal}, 64'd0);
    end
    imem_ack = 1'b0;

    // start is a level; dropping it once fetching has begun changes nothing
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < 9; i++) run_instr(tbl[i].ins, tbl[i].flags, tbl[i].waitc, tbl[i].e);

    for (int i = 0; i < 300; i++) begin
      ins = {ops[$urandom_range(0, 9)], 20'($urandom)};
      flg = 5'($urandom);
      run_instr(ins, flg, $urandom_range(0, 2), model(ins, flg));
    end

    guard = 0;
    while (pc_m != 8'hFF && guard < 300) begin
      run_instr(24'h000000, 5'h00, 0, model(24'h000000, 5'h00));
      guard++;
    end
    run_instr(24'h000000, 5'h00, 0, model(24'h000000, 5'h00));
    chk("pc_wrap", 64'(imem_addr), 64'd0);

    run_instr(24'hF12345, 5'h1F, 1, model(24'hF12345, 5'h1F));
    for (int i = 0; i < 4; i++) begin
      start    = ~start;
      imem_ack = 1'b1;
      @(negedge clk);
      chk("halt_hold", {sel_bus, imem_req, busy, halted}, 64'd1);
    end
    start = 1'b0; imem_ack = 1'b0;

    // Async reset mid-fetch
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_clears_illegal", 64'({illegal, halted}), 64'd0);
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fetch_before_rst", 64'(imem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_drops_req", 64'({imem_req, busy, imem_addr}), 64'd0);

    // Async reset mid-EXEC of an ALU_R kills the write strobe
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; imem_ack = 1'b1; imem_data = 24'h132100;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("exec_le_before_rst", 64'({LE, SRD}), 64'({1'b1, 4'h2}));
    #2 rst_n = 1'b0;
    #1 chk("rst_kills_le", 64'({LE, SRD, busy, imem_req}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", {sel_bus, imem_req, imem_addr, busy, halted, illegal}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
